rand_range: RTL and testbench
=============================

# rand_range

Downstream consumer of the free-running 64-bit xoroshiro128+ word stream. It maps each random word to a uniform integer in [0, bound) using multiply-shift with exact rejection (Lemire's method). Accepted values are buffered in a small FIFO and presented on a valid/ready stream, so consumers get unbiased bounded random numbers at up to one per cycle.

## Interface
- DEPTH, 4: output FIFO depth in entries (power of two, ≥2).
- clk  input  1  single clock; all state updates on rising edge.
- resn  input  1  synchronous, active-high reset.
- rnd_in  input  64  generator word; a new value is valid every cycle. Only rnd_in[63:32] is used, because the low bits are weak.
- bound_in  input  32  requested range s. 0 means full 2^32 range.
- bound_load  input  1  when high at an edge: latch bound_in and start threshold computation.
- busy  output  1  high while the threshold is being computed.
- out_data  output  32  head of FIFO.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- rej_cnt  output  16  saturating count of rejected samples since last load or reset.

## Operation
- Threshold t = (2^32 − s) mod s, computed by a 32-iteration restoring divider, one bit per cycle.
  - Dividend is (−s) mod 2^32; divisor is s.
  - For s=0: t=0 and the divider is skipped, so busy stays low.
- State machine:
  - IDLE/RUN → CALC on bound_load with s≠0.
  - CALC stays for exactly 32 cycles, then goes to RUN.
  - bound_load during CALC restarts CALC with the new bound; the iteration counter is reset.
- bound_load, any state:
  - FIFO, product stage and rej_cnt are cleared at that same edge.
  - bound register is updated.
- Stage P, product:
  - Condition: in RUN and credit available (fifo_count + P_valid < DEPTH).
  - Action: register m = rnd_in[63:32] × s as a 64-bit product, and set P_valid.
  - For s=0, m = {rnd_in[63:32], 32'b0}.
- Stage D, decide (edge after P):
  - l = m[31:0].
  - Reject if s≠0 and l < t. On reject, rej_cnt increments, saturating at 0xFFFF.
  - Otherwise push m[63:32] into the FIFO.
- FIFO:
  - Simultaneous push and pop is allowed at any occupancy, including full.
  - The credit scheme guarantees a push never hits full, so no value is dropped.
  - Order is preserved.
- Reset values:
  - bound=0, t=0, state IDLE→RUN (full-range pass-through).
  - busy=0, FIFO empty, out_valid=0, out_data=0, rej_cnt=0, P_valid=0.
- Reset has priority over bound_load. Reset mid-CALC aborts the computation.

## Timing
- bound_load sampled at edge E0 (s≠0):
  - busy=1 after E0.
  - Divider bits computed at E1..E32.
  - busy=0 and t valid after E32.
- After CALC:
  - First P capture at E33.
  - First FIFO write at E34.
  - out_valid=1 after E34, unless rejected.
- Steady state with out_ready=1: one sample per cycle through P; accepted values appear two edges after rnd_in is sampled.
- out_valid drops the cycle after the edge that pops the last entry with no same-edge push.
- out_data is stable while out_valid && !out_ready.
- busy and out_valid are never both high.

## Test plan
- Reset, no load, out_ready=1, rnd_in=0xDEADBEEF_00000000 → out_data=0xDEADBEEF two edges later; rej_cnt=0.
- bound_load s=6 → busy high exactly 32 cycles; t=4.
  - rnd_in upper=0xFFFFFFFF → out_data=5 (l=0xFFFFFFFA, accepted).
  - rnd_in upper=0x2AAAAAAB → rejected (l=2<4); rej_cnt=1; no push.
- Backpressure, s=0: out_ready=0 for 20 cycles → FIFO holds DEPTH entries, out_data stable, P stops capturing. Release → the DEPTH values drain in original order with no gaps or loss.
- bound_load s=1 while FIFO full → FIFO cleared and out_valid=0 after load edge. After CALC, all outputs are 0, rej_cnt stays 0.
- s=0x80000001, 1000 random samples → every out_data < 0x80000001. rej_cnt + accepted count equals P captures; rejection ratio is ~50%.
- resn asserted at cycle 10 of CALC → after that edge: busy=0, out_valid=0, rej_cnt=0, bound=0. Raw pass-through streaming then resumes.

Source files
------------

// File: rtl/rand_range_if.sv
// -----------------------------------------------------------------------------
// rand_range_if
// Output stream of rand_range: bounded random words on a valid/ready handshake.
//   out_data  : 32-bit head of the output FIFO (0 while out_valid is low)
//   out_valid : FIFO holds at least one entry
//   out_ready : consumer takes out_data on an edge where both are high
// master = producer (rand_range), slave = consumer.
// -----------------------------------------------------------------------------
interface rand_range_if;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/rand_range.sv
// -----------------------------------------------------------------------------
// rand_range
// Maps the upper 32 bits of a 64-bit generator word onto a uniform integer in
// [0, s) with multiply-shift plus exact rejection. The rejection threshold
// t = (2^32 - s) mod s comes from a bit-serial restoring divider. Accepted
// values are queued in a small FIFO behind a valid/ready stream.
//
// Ports
//   clk        : clock, all state on the rising edge
//   resn       : synchronous reset, active high (takes priority over bound_load)
//   rnd_in     : generator word, new every cycle; only [63:32] is used
//   bound_in   : range s, 0 selects the full 2^32 range
//   bound_load : latch bound_in, clear FIFO/product stage/rej_cnt, start divider
//   busy       : threshold computation in progress
//   out_if     : output stream (out_data / out_valid / out_ready)
//   rej_cnt    : saturating count of rejected samples since reset or load
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | just out of reset, moves to ST_RUN on the next edge
//   ST_CALC | divider running, one quotient bit per cycle for 32 cycles
//   ST_RUN  | threshold valid, product stage captures when FIFO credit exists
// -----------------------------------------------------------------------------
module rand_range #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          resn,
   input  logic [63:0]   rnd_in,
   input  logic [31:0]   bound_in,
   input  logic          bound_load,
   output logic          busy,
   rand_range_if.master  out_if,
   output logic [15:0]   rej_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Control FSM and restoring divider
   // ---------------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [31:0] bound_q, bound_d;
   logic [31:0] t_q, t_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] rem_q, rem_d;
   logic [4:0]  iter_q, iter_d;
   logic [32:0] rem_sh;

   always_ff @(posedge clk) begin
      if (resn) begin
         state_q <= ST_IDLE;
         bound_q <= '0;
         t_q     <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         bound_q <= bound_d;
         t_q     <= t_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         iter_q  <= iter_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bound_d = bound_q;
      t_d     = t_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      iter_d  = iter_q;
      rem_sh  = '0;

      unique case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_CALC: begin
            // Shift the next dividend bit into the partial remainder; the
            // remainder after a successful subtract is below s, so 32 bits hold it.
            rem_sh = {rem_q, dvd_q[31]};
            dvd_d  = {dvd_q[30:0], 1'b0};
            if (rem_sh >= {1'b0, bound_q}) begin
               rem_d = rem_sh[31:0] - bound_q;
            end else begin
               rem_d = rem_sh[31:0];
            end
            // iter_q is a down-counter loaded with 31; terminal count is the 32nd bit.
            if (iter_q == 5'd0) begin
               state_d = ST_RUN;
               t_d     = rem_d;
            end else begin
               iter_d = iter_q - 5'd1;
            end
         end
         ST_RUN: state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      // A load overrides whatever the divider was doing, including a restart mid-CALC.
      if (bound_load) begin
         bound_d = bound_in;
         t_d     = '0;
         rem_d   = '0;
         dvd_d   = 32'd0 - bound_in;
         iter_d  = 5'd31;
         if (bound_in == 32'd0) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_CALC;
         end
      end
   end

   assign busy = (state_q == ST_CALC);

   // ---------------------------------------------------------------------------
   // Product stage (P), decide stage (D) and output FIFO
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0][31:0] mem_q;
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic                   p_valid_q;
   logic [63:0]            p_m_q;
   logic [15:0]            rej_q;

   logic [31:0] rnd_hi;
   logic [31:0] unused_rnd_lo;
   logic [63:0] prod;
   logic [CW:0] occ;
   logic        cap;
   logic        reject;
   logic        push;
   logic        pop;

   assign rnd_hi        = rnd_in[63:32];
   assign unused_rnd_lo = rnd_in[31:0];

   // s = 0 means a 2^32 range, so the word itself is the result and l is 0.
   assign prod = (bound_q == 32'd0) ? {rnd_hi, 32'd0}
                                    : ({32'd0, rnd_hi} * {32'd0, bound_q});

   // Credit counts the sample already in P, so a push can never find the FIFO full.
   assign occ    = {1'b0, count_q} + {{CW{1'b0}}, p_valid_q};
   assign cap    = (state_q == ST_RUN) && (occ < (CW+1)'(DEPTH));
   assign reject = p_valid_q && (bound_q != 32'd0) && (p_m_q[31:0] < t_q);
   assign push   = p_valid_q && !reject;
   assign pop    = out_if.out_valid && out_if.out_ready;

   always_ff @(posedge clk) begin
      if (resn || bound_load) begin
         p_valid_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rej_q     <= '0;
      end else begin
         p_valid_q <= cap;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (reject && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'd1;
         end
      end
   end

   // Data storage needs no reset: out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (cap) begin
         p_m_q <= prod;
      end
      if (push) begin
         mem_q[wr_ptr_q] <= p_m_q[63:32];
      end
   end

   assign out_if.out_valid = (count_q != '0);
   assign out_if.out_data  = out_if.out_valid ? mem_q[rd_ptr_q] : 32'd0;
   assign rej_cnt          = rej_q;

endmodule

// File: tb/tb_rand_range.sv
module tb_rand_range;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resn;
   logic [63:0] rnd_in;
   logic [31:0] bound_in;
   logic        bound_load;
   logic        busy;
   logic [15:0] rej_cnt;

   rand_range_if u_if();

   rand_range #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .resn       (resn),
      .rnd_in     (rnd_in),
      .bound_in   (bound_in),
      .bound_load (bound_load),
      .busy       (busy),
      .out_if     (u_if),
      .rej_cnt    (rej_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   // Reference Lemire mapping: returns {reject, value}.
   function automatic logic [32:0] model(input logic [31:0] r, input logic [31:0] s);
      logic [63:0] m;
      logic [63:0] t;
      if (s == 32'd0) return {1'b0, r};
      m = 64'(r) * 64'(s);
      t = (64'h1_0000_0000 - 64'(s)) % 64'(s);
      return {(m[31:0] < t[31:0]), m[63:32]};
   endfunction

   task automatic test_reset();
      bit found;
      resn = 1'b1; bound_load = 1'b0; bound_in = '0;
      rnd_in = 64'hDEADBEEF_00000000; u_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", u_if.out_valid); end
      n_checks++; if (u_if.out_data !== 32'd0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", u_if.out_data); end
      n_checks++; if (rej_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_rej: got %0d expected 0", rej_cnt); end
      resn = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         if (u_if.out_valid) found = 1'b1;
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL passthru_valid: got timeout expected out_valid"); end
      n_checks++; if (u_if.out_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL passthru_data: got %h expected deadbeef", u_if.out_data); end
      n_checks++; if (rej_cnt !== 16'd0) begin n_errors++; $display("FAIL passthru_rej: got %0d expected 0", rej_cnt); end
      rnd_in = 64'h12345678_9ABCDEF0;
      @(posedge clk); #1;
      n_checks++; if (u_if.out_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL latency_1edge: got %h expected deadbeef", u_if.out_data); end
      @(posedge clk); #1;
      n_checks++; if (u_if.out_data !== 32'h12345678) begin n_errors++; $display("FAIL latency_2edge: got %h expected 12345678", u_if.out_data); end
   endtask

   task automatic test_calc_s6();
      int busy_cycles;
      int exp_rej;
      logic [31:0] v;
      logic [31:0] head;
      logic [32:0] r;
      exp_q.delete();
      u_if.out_ready = 1'b1;
      bound_in = 32'd6; bound_load = 1'b1;
      @(posedge clk); #1;
      bound_load = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL s6_busy_start: got %b expected 1", busy); end
      n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL s6_load_clear: got %b expected 0", u_if.out_valid); end
      busy_cycles = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         n_checks++; if (busy && u_if.out_valid) begin n_errors++; $display("FAIL s6_busy_valid_overlap: got both high expected exclusive"); end
         if (busy) busy_cycles++;
         else break;
      end
      n_checks++; if (busy_cycles != 32) begin n_errors++; $display("FAIL s6_busy_len: got %0d expected 32", busy_cycles); end
      exp_rej = 0;
      for (int j = 0; j < 12; j++) begin
         if (j == 2) begin
            n_checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 32'd5) begin n_errors++; $display("FAIL s6_first_write: got valid=%b data=%h expected valid=1 data=5", u_if.out_valid, u_if.out_data); end
         end
         if (j == 3) begin
            n_checks++; if (rej_cnt !== 16'd1 || u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL s6_reject: got rej=%0d valid=%b expected rej=1 valid=0", rej_cnt, u_if.out_valid); end
         end
         if (u_if.out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL s6_sb_extra: got %h expected no output", u_if.out_data); end
            else begin
               head = exp_q.pop_front();
               if (u_if.out_data !== head) begin n_errors++; $display("FAIL s6_sb_data: got %h expected %h", u_if.out_data, head); end
            end
         end
         if (j == 0) v = 32'hFFFFFFFF;
         else if (j == 1) v = 32'h2AAAAAAB;
         else if (j < 6) v = 32'($urandom);
         else v = 32'hFFFFFFFF;
         r = model(v, 32'd6);
         if (r[32]) exp_rej++;
         else exp_q.push_back(r[31:0]);
         rnd_in = {v, 32'($urandom)};
         @(posedge clk); #1;
      end
      n_checks++; if (rej_cnt !== 16'(exp_rej)) begin n_errors++; $display("FAIL s6_rej_total: got %0d expected %0d", rej_cnt, exp_rej); end
      n_checks++; if (exp_q.size() != 2) begin n_errors++; $display("FAIL s6_sb_pending: got %0d expected 2", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int idx;
      bit found;
      logic [31:0] head;
      exp_q.delete();
      u_if.out_ready = 1'b0;
      bound_in = 32'd0; bound_load = 1'b1;
      @(posedge clk); #1;
      bound_load = 1'b0;
      n_checks++; if (busy !== 1'b0 || u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_load: got busy=%b valid=%b expected 0 0", busy, u_if.out_valid); end
      idx = 0;
      for (int i = 0; i < 20; i++) begin
         rnd_in = {32'hA0000000 + 32'(idx), 32'($urandom)};
         if (idx < DEPTH) exp_q.push_back(32'hA0000000 + 32'(idx));
         idx++;
         @(posedge clk); #1;
         if (i >= 2) begin
            n_checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 32'hA0000000) begin n_errors++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=a0000000", u_if.out_valid, u_if.out_data); end
         end
      end
      u_if.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         head = exp_q.pop_front();
         n_checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== head) begin n_errors++; $display("FAIL bp_drain: got valid=%b data=%h expected valid=1 data=%h", u_if.out_valid, u_if.out_data, head); end
         rnd_in = {32'hA0000000 + 32'(idx), 32'($urandom)};
         idx++;
         @(posedge clk); #1;
      end
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         if (u_if.out_valid) begin
            found = 1'b1;
            n_checks++; if (u_if.out_data < 32'hA0000014) begin n_errors++; $display("FAIL bp_no_capture_when_full: got %h expected >= a0000014", u_if.out_data); end
         end else begin
            rnd_in = {32'hA0000000 + 32'(idx), 32'($urandom)};
            idx++;
            @(posedge clk); #1;
         end
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL bp_resume: got timeout expected out_valid"); end
   endtask

   task automatic test_load_full();
      bit done;
      int nvalid;
      exp_q.delete();
      u_if.out_ready = 1'b0;
      bound_in = 32'd0; bound_load = 1'b1;
      @(posedge clk); #1;
      bound_load = 1'b0;
      repeat (10) begin
         rnd_in = {32'($urandom), 32'($urandom)};
         @(posedge clk); #1;
      end
      n_checks++; if (u_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL lf_full: got %b expected 1", u_if.out_valid); end
      bound_in = 32'd1; bound_load = 1'b1;
      @(posedge clk); #1;
      bound_load = 1'b0;
      n_checks++; if (u_if.out_valid !== 1'b0 || busy !== 1'b1 || u_if.out_data !== 32'd0) begin n_errors++; $display("FAIL lf_clear: got valid=%b busy=%b data=%h expected 0 1 0", u_if.out_valid, busy, u_if.out_data); end
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk); #1;
         if (!busy) done = 1'b1;
      end
      n_checks++; if (!done) begin n_errors++; $display("FAIL lf_calc_end: got busy stuck expected busy low"); end
      u_if.out_ready = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         rnd_in = {32'($urandom) | 32'h8000_0000, 32'($urandom)};
         @(posedge clk); #1;
         if (u_if.out_valid) begin
            nvalid++;
            n_checks++; if (u_if.out_data !== 32'd0) begin n_errors++; $display("FAIL lf_s1_data: got %h expected 0", u_if.out_data); end
         end
      end
      n_checks++; if (nvalid < 15) begin n_errors++; $display("FAIL lf_s1_count: got %0d expected >= 15", nvalid); end
      n_checks++; if (rej_cnt !== 16'd0) begin n_errors++; $display("FAIL lf_s1_rej: got %0d expected 0", rej_cnt); end
   endtask

   task automatic test_random_wide();
      localparam logic [31:0] S = 32'h80000001;
      localparam int N = 1000;
      int exp_rej;
      int pops;
      bit done;
      logic [31:0] v;
      logic [31:0] head;
      logic [32:0] r;
      exp_q.delete();
      u_if.out_ready = 1'b1;
      bound_in = S; bound_load = 1'b1;
      @(posedge clk); #1;
      bound_load = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk); #1;
         if (!busy) done = 1'b1;
      end
      n_checks++; if (!done) begin n_errors++; $display("FAIL rw_calc_end: got busy stuck expected busy low"); end
      exp_rej = 0;
      pops = 0;
      for (int j = 0; j < N + 4; j++) begin
         if (u_if.out_valid) begin
            pops++;
            n_checks++; if (u_if.out_data >= S) begin n_errors++; $display("FAIL rw_range: got %h expected < %h", u_if.out_data, S); end
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL rw_sb_extra: got %h expected no output", u_if.out_data); end
            else begin
               head = exp_q.pop_front();
               if (u_if.out_data !== head) begin n_errors++; $display("FAIL rw_sb_data: got %h expected %h", u_if.out_data, head); end
            end
         end
         v = (j < N) ? 32'($urandom) : 32'hFFFFFFFF;
         r = model(v, S);
         if (r[32]) exp_rej++;
         else exp_q.push_back(r[31:0]);
         rnd_in = {v, 32'($urandom)};
         @(posedge clk); #1;
      end
      n_checks++; if (rej_cnt !== 16'(exp_rej)) begin n_errors++; $display("FAIL rw_rej_total: got %0d expected %0d", rej_cnt, exp_rej); end
      n_checks++; if (int'(rej_cnt) + pops != N + 2) begin n_errors++; $display("FAIL rw_conservation: got %0d expected %0d", int'(rej_cnt) + pops, N + 2); end
      n_checks++; if (rej_cnt < 16'd350 || rej_cnt > 16'd650) begin n_errors++; $display("FAIL rw_ratio: got %0d expected 350..650", rej_cnt); end
      n_checks++; if (exp_q.size() != 2) begin n_errors++; $display("FAIL rw_sb_pending: got %0d expected 2", exp_q.size()); end
   endtask

   task automatic test_reset_mid_calc();
      bit found;
      u_if.out_ready = 1'b1;
      bound_in = 32'd6; bound_load = 1'b1;
      @(posedge clk); #1;
      bound_load = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rc_in_calc: got %b expected 1", busy); end
      resn = 1'b1;
      @(posedge clk); #1;
      resn = 1'b0;
      n_checks++; if (busy !== 1'b0 || u_if.out_valid !== 1'b0 || rej_cnt !== 16'd0 || u_if.out_data !== 32'd0) begin n_errors++; $display("FAIL rc_after_reset: got busy=%b valid=%b rej=%0d data=%h expected 0 0 0 0", busy, u_if.out_valid, rej_cnt, u_if.out_data); end
      rnd_in = 64'hCAFEF00D_12345678;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         if (u_if.out_valid) found = 1'b1;
      end
      n_checks++; if (!found || u_if.out_data !== 32'hCAFEF00D) begin n_errors++; $display("FAIL rc_passthru: got valid=%b data=%h expected valid=1 data=cafef00d", found, u_if.out_data); end
   endtask

   initial begin
      resn = 1'b1; bound_load = 1'b0; bound_in = '0; rnd_in = '0; u_if.out_ready = 1'b0;
      test_reset();
      test_calc_s6();
      test_backpressure();
      test_load_full();
      test_random_wide();
      test_reset_mid_calc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

endmodule
